// File: rtl/draw_image_blit.sv
// draw_image_blit: raster-order image blitter.
// On an accepted start, walks an IMG_W x IMG_H image ROM one address per cycle.
// Each ROM word is plotted to the VGA adapter at (x_origin+cx, y_origin+cy).
// Pixels that land off-screen are clipped; they still take their slot.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               begin a draw (sampled only while idle)
//   x_origin, y_origin  screen position of image pixel (0,0), latched on start
//   rom_addr, rom_q     external image ROM; data valid ROM_LAT cycles after address
//   x, y, colour, plot  registered pixel write to the VGA adapter
//   busy                high from accepted start through the done pulse
//   done                one-cycle pulse after the last pixel slot
//
// Optional feature: define DRAW_BLIT_TRANSP_EN to suppress plotting of pixels
// whose colour equals TRANSP_COL (sprite mode). Timing is identical either way.
module draw_image_blit #(
   parameter int IMG_W    = 80,
   parameter int IMG_H    = 40,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int ADDR_W   = 12,
   parameter int COLOUR_W = 9,
   parameter int ROM_LAT  = 1,
   parameter logic [COLOUR_W-1:0] TRANSP_COL = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          x_origin,
   input  logic [6:0]          y_origin,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int CX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int CY_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   // One bit wider than the screen coordinate so off-screen sums never wrap.
   localparam int XS_W = ((CX_W > 8) ? CX_W : 8) + 1;
   localparam int YS_W = ((CY_W > 7) ? CY_W : 7) + 1;
   localparam logic [CX_W-1:0] CX_LAST = CX_W'(IMG_W - 1);
   localparam logic [CY_W-1:0] CY_LAST = CY_W'(IMG_H - 1);

`ifdef DRAW_BLIT_TRANSP_EN
   localparam logic TRANSP_ON = 1'b1;
`else
   localparam logic TRANSP_ON = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t state;

   logic [CX_W-1:0] cx;
   logic [CY_W-1:0] cy;
   logic [7:0]      x_org;
   logic [6:0]      y_org;

   // (cx, cy, valid) delayed to line up with rom_q
   logic [CX_W-1:0]    pcx [ROM_LAT];
   logic [CY_W-1:0]    pcy [ROM_LAT];
   logic [ROM_LAT-1:0] pv;

   logic [XS_W-1:0] x_sum;
   logic [YS_W-1:0] y_sum;
   logic            clipped;
   logic            transp;
   logic            last_issue;

   always_comb begin
      x_sum      = XS_W'(x_org) + XS_W'(pcx[ROM_LAT-1]);
      y_sum      = YS_W'(y_org) + YS_W'(pcy[ROM_LAT-1]);
      clipped    = (32'(x_sum) >= SCREEN_W) || (32'(y_sum) >= SCREEN_H);
      transp     = TRANSP_ON && (rom_q == TRANSP_COL);
      last_issue = (cx == CX_LAST) && (cy == CY_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cx       <= '0;
         cy       <= '0;
         x_org    <= '0;
         y_org    <= '0;
         rom_addr <= '0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         plot     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pv       <= '0;
         for (int unsigned i = 0; i < ROM_LAT; i++) begin
            pcx[i] <= '0;
            pcy[i] <= '0;
         end
      end else begin
         // Each address presented during ISSUE enters the pipeline on the following edge.
         pv[0]  <= (state == ISSUE);
         pcx[0] <= cx;
         pcy[0] <= cy;
         for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pv[i]  <= pv[i-1];
            pcx[i] <= pcx[i-1];
            pcy[i] <= pcy[i-1];
         end

         // Output stage: x/y/colour hold their last plotted value otherwise.
         plot <= 1'b0;
         if (pv[ROM_LAT-1] && !clipped && !transp) begin
            plot   <= 1'b1;
            x      <= x_sum[7:0];
            y      <= y_sum[6:0];
            colour <= rom_q;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  x_org    <= x_origin;
                  y_org    <= y_origin;
                  cx       <= '0;
                  cy       <= '0;
                  rom_addr <= '0;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (last_issue) begin
                  state <= DRAIN;
               end else begin
                  // Linear address tracks cy*IMG_W+cx without a multiplier.
                  rom_addr <= rom_addr + 1'b1;
                  if (cx == CX_LAST) begin
                     cx <= '0;
                     cy <= cy + 1'b1;
                  end else begin
                     cx <= cx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (pv == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_image_blit.sv
// Bench for draw_image_blit: three instances (80x40 lat 1, 4x2 lat 3, 1x1 lat 2)
// checked every cycle against a timing/arithmetic model, plus literal expectations.
module tb_draw_image_blit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [3];
   logic       start [3];
   logic [7:0] xo    [3];
   logic [6:0] yo    [3];

   logic [11:0] addr_a;
   logic [2:0]  addr_b;
   logic [0:0]  addr_c;
   logic [8:0]  q_a, q_b, q_c, b1, b2, c1;

   logic [7:0] x_a, x_b, x_c;
   logic [6:0] y_a, y_b, y_c;
   logic [8:0] col_a, col_b, col_c;
   logic       plot_a, plot_b, plot_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

   draw_image_blit #(.IMG_W(80), .IMG_H(40), .ADDR_W(12), .ROM_LAT(1)) dut_a (
      .clk(clk), .reset(rst[0]), .start(start[0]), .x_origin(xo[0]), .y_origin(yo[0]),
      .rom_addr(addr_a), .rom_q(q_a), .x(x_a), .y(y_a), .colour(col_a),
      .plot(plot_a), .busy(busy_a), .done(done_a));

   draw_image_blit #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .ROM_LAT(3), .TRANSP_COL(9'h1FF)) dut_b (
      .clk(clk), .reset(rst[1]), .start(start[1]), .x_origin(xo[1]), .y_origin(yo[1]),
      .rom_addr(addr_b), .rom_q(q_b), .x(x_b), .y(y_b), .colour(col_b),
      .plot(plot_b), .busy(busy_b), .done(done_b));

   draw_image_blit #(.IMG_W(1), .IMG_H(1), .ADDR_W(1), .ROM_LAT(2)) dut_c (
      .clk(clk), .reset(rst[2]), .start(start[2]), .x_origin(xo[2]), .y_origin(yo[2]),
      .rom_addr(addr_c), .rom_q(q_c), .x(x_c), .y(y_c), .colour(col_c),
      .plot(plot_c), .busy(busy_c), .done(done_c));

   localparam int PW [3] = '{80, 4, 1};
   localparam int PH [3] = '{40, 2, 1};
   localparam int PL [3] = '{1, 3, 2};
   localparam int TC [3] = '{0, 511, 0};
`ifdef DRAW_BLIT_TRANSP_EN
   localparam bit TRON = 1'b1;
`else
   localparam bit TRON = 1'b0;
`endif

   int rom_mode = 0;

   function automatic logic [8:0] rom_fn(int i, int p);
      if (i == 0) begin
         if (rom_mode == 1) return (p % 2 == 1) ? 9'h1FF : 9'h000;
         return 9'((p % 511) + 1);
      end
      if (i == 1) return 9'(p);
      return 9'h155;
   endfunction

   // Bench-side ROMs with the latency each instance expects.
   always @(posedge clk) begin
      q_a <= rom_fn(0, int'(addr_a));
      b1  <= rom_fn(1, int'(addr_b));
      b2  <= b1;
      q_b <= b2;
      c1  <= rom_fn(2, int'(addr_c));
      q_c <= c1;
   end

   // Output gathering
   int o_x [3], o_y [3], o_col [3], o_addr [3];
   bit o_plot [3], o_busy [3], o_done [3];
   always_comb begin
      o_x[0] = int'(x_a);   o_x[1] = int'(x_b);   o_x[2] = int'(x_c);
      o_y[0] = int'(y_a);   o_y[1] = int'(y_b);   o_y[2] = int'(y_c);
      o_col[0] = int'(col_a); o_col[1] = int'(col_b); o_col[2] = int'(col_c);
      o_addr[0] = int'(addr_a); o_addr[1] = int'(addr_b); o_addr[2] = int'(addr_c);
      o_plot[0] = plot_a; o_plot[1] = plot_b; o_plot[2] = plot_c;
      o_busy[0] = busy_a; o_busy[1] = busy_b; o_busy[2] = busy_c;
      o_done[0] = done_a; o_done[1] = done_b; o_done[2] = done_c;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(string nm, int got, int exp_v);
      n_checks++;
      if (got == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
   endtask

   // Model state: a draw is described only by its accept edge and origin.
   int ec = 0;
   bit act [3];
   int t0 [3], mox [3], moy [3];
   int plot_cnt [3], done_cnt [3], done_rel [3], first_rel [3], first_x [3];
   int last_x [3], last_y [3];
   int col_log [$];
   string dn [3] = '{"A", "B", "C"};

   function automatic bit m_busy(int i, int e);
      return act[i] && ((e - t0[i]) <= PW[i] * PH[i] + PL[i] + 1);
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         act[i] = 1'b0; t0[i] = 0; done_cnt[i] = 0; plot_cnt[i] = 0;
         first_rel[i] = -1; first_x[i] = -1; done_rel[i] = -1;
      end
      forever begin
         @(posedge clk);
         ec = ec + 1;
         for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
               act[i] = 1'b0;
            end else if (start[i] && !m_busy(i, ec - 1)) begin
               act[i] = 1'b1; t0[i] = ec; mox[i] = int'(xo[i]); moy[i] = int'(yo[i]);
               plot_cnt[i] = 0; first_rel[i] = -1; first_x[i] = -1;
               if (i == 1) col_log.delete();
            end
         end
      end
   end

   // Compare process: every cycle, every instance.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            int n, rel, p, px, py;
            bit e_plot;
            logic [8:0] col;
            n = PW[i] * PH[i];
            rel = ec - t0[i];
            p = rel - PL[i] - 1;
            e_plot = 1'b0;
            px = 0; py = 0; col = '0;
            if (act[i] && p >= 0 && p < n) begin
               px = mox[i] + p % PW[i];
               py = moy[i] + p / PW[i];
               col = rom_fn(i, p);
               e_plot = (px < 160) && (py < 120) && !(TRON && int'(col) == TC[i]);
            end
            check($sformatf("%s.busy@%0d", dn[i], ec), int'(o_busy[i]), int'(m_busy(i, ec)));
            check($sformatf("%s.done@%0d", dn[i], ec), int'(o_done[i]),
                  int'(act[i] && rel == n + PL[i] + 1));
            check($sformatf("%s.plot@%0d", dn[i], ec), int'(o_plot[i]), int'(e_plot));
            if (e_plot) begin
               check($sformatf("%s.x@%0d", dn[i], ec), o_x[i], px);
               check($sformatf("%s.y@%0d", dn[i], ec), o_y[i], py);
               check($sformatf("%s.colour@%0d", dn[i], ec), o_col[i], int'(col));
            end
            if (act[i] && rel >= 0 && rel < n)
               check($sformatf("%s.rom_addr@%0d", dn[i], ec), o_addr[i], rel);
            if (o_plot[i]) begin
               plot_cnt[i]++;
               if (first_rel[i] < 0) begin first_rel[i] = rel; first_x[i] = o_x[i]; end
               last_x[i] = o_x[i]; last_y[i] = o_y[i];
               if (i == 1) col_log.push_back(o_col[i]);
            end
            if (o_done[i]) begin done_cnt[i]++; done_rel[i] = rel; end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(int i, int px, int py);
      xo[i] = 8'(px); yo[i] = 7'(py); start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic wait_idle(int i);
      int k;
      k = 0;
      tick();
      while (m_busy(i, ec) && k < 10000) begin tick(); k++; end
      if (k >= 10000) check($sformatf("%s.timeout", dn[i]), 1, 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; xo[i] = '0; yo[i] = '0;
      end
      repeat (3) tick();
      check("reset.x", int'(x_a), 0);
      check("reset.y", int'(y_a), 0);
      check("reset.colour", int'(col_a), 0);
      check("reset.rom_addr", int'(addr_a), 0);
      check("reset.busy", int'(busy_a), 0);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      tick();

      // A: origin (39,39); B: 4x2 lat 3 at (0,0); C: 1x1 at bottom-right corner
      xo[0] = 8'd39; yo[0] = 7'd39; xo[1] = 8'd0; yo[1] = 7'd0; xo[2] = 8'd159; yo[2] = 7'd119;
      for (int i = 0; i < 3; i++) start[i] = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) start[i] = 1'b0;

      wait_idle(1);
      check("B.plots", plot_cnt[1], 8);
      check("B.first_plot_cycle", first_rel[1], 4);
      check("B.done_cycle", done_rel[1], 12);
      check("B.colour_count", col_log.size(), 8);
      for (int k = 0; k < 8 && k < col_log.size(); k++)
         check($sformatf("B.colour[%0d]", k), col_log[k], k);
      wait_idle(2);
      check("C.plots", plot_cnt[2], 1);
      check("C.x", last_x[2], 159);
      check("C.y", last_y[2], 119);
      check("C.done_cycle", done_rel[2], 4);
      wait_idle(0);
      check("A1.plots", plot_cnt[0], 3200);
      check("A1.first_plot_cycle", first_rel[0], 2);
      check("A1.first_x", first_x[0], 39);
      check("A1.last_x", last_x[0], 118);
      check("A1.last_y", last_y[0], 78);
      check("A1.done_cycle", done_rel[0], 3202);
      check("A1.busy_after", int'(busy_a), 0);

      // C fully clipped just past each screen edge
      pulse_start(2, 160, 0);
      wait_idle(2);
      check("C.clipx.plots", plot_cnt[2], 0);
      check("C.clipx.done_cycle", done_rel[2], 4);
      pulse_start(2, 0, 120);
      wait_idle(2);
      check("C.clipy.plots", plot_cnt[2], 0);

      // A: clipped draw with an ignored start re-pulse mid-draw
      pulse_start(0, 120, 100);
      repeat (98) tick();
      pulse_start(0, 10, 10);
      wait_idle(0);
      check("A2.plots", plot_cnt[0], 800);
      check("A2.last_x", last_x[0], 159);
      check("A2.last_y", last_y[0], 119);
      check("A2.done_cycle", done_rel[0], 3202);
      check("A2.done_count", done_cnt[0], 2);

      // A: reset mid-draw, then redraw with alternating 0/1FF ROM
      pulse_start(0, 5, 5);
      repeat (48) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      check("A3.abort_plot", int'(plot_a), 0);
      check("A3.abort_busy", int'(busy_a), 0);
      repeat (5) tick();
      check("A3.abort_done_count", done_cnt[0], 2);
      rom_mode = 1;
      pulse_start(0, 0, 0);
      wait_idle(0);
      check("A4.plots", plot_cnt[0], TRON ? 1600 : 3200);
      check("A4.first_x", first_x[0], TRON ? 1 : 0);
      check("A4.first_plot_cycle", first_rel[0], TRON ? 3 : 2);
      check("A4.done_count", done_cnt[0], 3);
      rom_mode = 0;

      // B: start held high re-triggers on the first idle cycle after done
      xo[1] = 8'd10; yo[1] = 7'd20; start[1] = 1'b1;
      repeat (20) tick();
      start[1] = 1'b0;
      wait_idle(1);
      check("B.held.done_count", done_cnt[1], 3);
      check("B.held.last_x", last_x[1], 13);
      check("B.held.last_y", last_y[1], 21);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
